// File: rtl/fp_cmp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp_cmp_pkg                                                                 |
// | Shared definitions for the shared FP greater-or-equal comparator:          |
// | exception encodings, field positions and the in-flight tag type.           |
// | Optional feature macro: FP_CMP_UNORD_EN (adds the unordered tag bit).      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fp_cmp_pkg;

  // Two-bit exception field at the top of every operand.
  localparam logic [1:0] EXN_ZERO = 2'b00;
  localparam logic [1:0] EXN_NORM = 2'b01;
  localparam logic [1:0] EXN_INF  = 2'b10;
  localparam logic [1:0] EXN_NAN  = 2'b11;

  // Format below the exception field: sign, 11-bit exponent, 23-bit mantissa.
  localparam int EXP_W = 11;
  localparam int MAN_W = 23;

  // Requester id width; covers up to 8 requesters.
  localparam int ID_W = 3;

  // Field positions for an operand whose MSB index is w.
  function automatic int exn_lsb(input int w);
    return w - 1;
  endfunction

  function automatic int sign_idx(input int w);
    return w - 2;
  endfunction

  // Exponent and mantissa are contiguous, so together they form an unsigned
  // magnitude key ending at this index.
  function automatic int mag_msb(input int w);
    return w - 3;
  endfunction

  // Tag carried alongside each compare through the subtractor pipeline.
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
`ifdef FP_CMP_UNORD_EN
    logic            unord;
`endif
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/fp_cmp_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp_cmp_core                                                                |
// | Pipelined FP subtractor (X - Y) followed by a registered ge decision.      |
// | Total latency SUB_LAT+1 cycles. Only the exception and sign fields of the  |
// | difference are formed, since the decision uses nothing else.               |
// | Optional feature macro: FP_CMP_UNORD_EN (exports the R-is-NaN flag).       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fp_cmp_core
  import fp_cmp_pkg::*;
#(
  parameter int WIDTH   = 36,
  parameter int SUB_LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [WIDTH:0] x,
  input  logic [WIDTH:0] y,
`ifdef FP_CMP_UNORD_EN
  output logic           r_nan,
`endif
  output logic           ge
);

  localparam int EXN_LSB  = exn_lsb(WIDTH);
  localparam int SIGN_IDX = sign_idx(WIDTH);
  localparam int MAG_MSB  = mag_msb(WIDTH);

  logic [1:0]         x_exn, y_exn;
  logic               x_sgn, y_sgn, x_neg, y_neg, x_gt;
  logic [MAG_MSB+1:0] x_mag, y_mag;
  logic [2:0]         r_res;          // {exn, sign} of the difference
  logic [2:0]         sub_d [SUB_LAT];
  logic [2:0]         sub_q [SUB_LAT];
  logic               ge_d, ge_q, nan_d, nan_q;

  // Difference classification: NaN/inf rules first, then a signed magnitude order.
  always_comb begin
    x_exn = x[WIDTH:EXN_LSB];
    y_exn = y[WIDTH:EXN_LSB];
    x_sgn = x[SIGN_IDX];
    y_sgn = y[SIGN_IDX];
    // Leading 1 keeps the smallest normal distinct from zero.
    x_mag = (x_exn == EXN_ZERO) ? '0 : {1'b1, x[MAG_MSB:0]};
    y_mag = (y_exn == EXN_ZERO) ? '0 : {1'b1, y[MAG_MSB:0]};
    x_neg = x_sgn && (x_exn != EXN_ZERO);
    y_neg = y_sgn && (y_exn != EXN_ZERO);
    x_gt  = x_neg ? (y_neg && (x_mag < y_mag)) : (y_neg || (x_mag > y_mag));
    r_res = {EXN_ZERO, 1'b0};
    if ((x_exn == EXN_NAN) || (y_exn == EXN_NAN)) begin
      r_res = {EXN_NAN, 1'b0};
    end else if ((x_exn == EXN_INF) && (y_exn == EXN_INF)) begin
      // inf - inf of equal sign has no value.
      r_res = (x_sgn == y_sgn) ? {EXN_NAN, 1'b0} : {EXN_INF, x_sgn};
    end else if (x_exn == EXN_INF) begin
      r_res = {EXN_INF, x_sgn};
    end else if (y_exn == EXN_INF) begin
      r_res = {EXN_INF, ~y_sgn};
    end else if ((x_mag == y_mag) && (x_neg == y_neg)) begin
      r_res = {EXN_ZERO, 1'b0};
    end else begin
      r_res = {EXN_NORM, ~x_gt};
    end
  end

  // Subtractor pipeline stages and the decision on the final difference.
  always_comb begin
    sub_d[0] = r_res;
    for (int k = 1; k < SUB_LAT; k++) begin
      sub_d[k] = sub_q[k-1];
    end
    case (sub_q[SUB_LAT-1][2:1])
      EXN_ZERO: ge_d = 1'b1;
      EXN_NAN:  ge_d = 1'b0;
      default:  ge_d = ~sub_q[SUB_LAT-1][0];
    endcase
    nan_d = (sub_q[SUB_LAT-1][2:1] == EXN_NAN);
  end

  // Pipeline and decision registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SUB_LAT; k++) begin
        sub_q[k] <= '0;
      end
      ge_q  <= 1'b0;
      nan_q <= 1'b0;
    end else begin
      for (int k = 0; k < SUB_LAT; k++) begin
        sub_q[k] <= sub_d[k];
      end
      ge_q  <= ge_d;
      nan_q <= nan_d;
    end
  end

  assign ge = ge_q;
`ifdef FP_CMP_UNORD_EN
  assign r_nan = nan_q;
`else
  logic unused_nan;
  assign unused_nan = nan_q;
`endif

endmodule
`default_nettype wire

// File: rtl/fp_cmp_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp_cmp_arbiter                                                             |
// | Round-robin sharing of one pipelined FP ge comparator among NUM_REQ        |
// | requesters. Tags route each result back to its issuer; per-requester       |
// | outstanding counters bound in-flight work.                                 |
// | Optional feature macro: FP_CMP_UNORD_EN (rsp_unord port and tag bit).      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fp_cmp_arbiter
  import fp_cmp_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 36,
  parameter int SUB_LAT   = 2,
  parameter int OUTST_MAX = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*(WIDTH+1)-1:0] req_a,
  input  logic [NUM_REQ*(WIDTH+1)-1:0] req_b,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic                         rsp_ge,
`ifdef FP_CMP_UNORD_EN
  output logic                         rsp_unord,
`endif
  output logic                         busy
);

  localparam int OW       = 3;
  localparam int OPW      = WIDTH + 1;
  localparam int EXN_LSB  = exn_lsb(WIDTH);
  localparam logic [OW-1:0] OUTST_LIM = OW'(OUTST_MAX);

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [OW-1:0]      outst_q [NUM_REQ];
  logic [OW-1:0]      outst_d [NUM_REQ];
  tag_t               tag_q [SUB_LAT+1];
  tag_t               tag_d [SUB_LAT+1];
  tag_t               tag_out;
  logic [NUM_REQ-1:0] elig;
  logic               grant_any;
  logic [ID_W-1:0]    grant_id;
  logic [WIDTH:0]     op_a, op_b;
  logic               core_ge;
  int                 idx;

  assign tag_out = tag_q[SUB_LAT];

  // Decode the output-stage tag into a one-hot response pulse.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = tag_out.valid && (tag_out.id == ID_W'(i));
    end
  end

  // Eligibility, round-robin pick from ptr, and granted-operand mux.
  always_comb begin
    grant_id  = '0;
    grant_any = 1'b0;
    idx       = 0;
    op_a      = '0;
    op_b      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // A full requester may still issue when its oldest compare retires now.
      elig[i] = req_valid[i] && ((outst_q[i] < OUTST_LIM) ||
                ((outst_q[i] == OUTST_LIM) && rsp_valid[i]));
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any && elig[idx]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant_any && (grant_id == ID_W'(i));
      if (req_ready[i]) begin
        op_a = req_a[i*OPW +: OPW];
        op_b = req_b[i*OPW +: OPW];
      end
    end
  end

  // Next-state: pointer, outstanding counters and tag shift register.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_any) begin
      ptr_d = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + ID_W'(1);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      outst_d[i] = outst_q[i];
      if (req_ready[i] && !rsp_valid[i]) outst_d[i] = outst_q[i] + OW'(1);
      else if (!req_ready[i] && rsp_valid[i]) outst_d[i] = outst_q[i] - OW'(1);
    end
    tag_d[0].valid = grant_any;
    tag_d[0].id    = grant_id;
`ifdef FP_CMP_UNORD_EN
    // Operand NaNs are flagged at issue; R's NaN is added at the output.
    tag_d[0].unord = grant_any && ((op_a[WIDTH:EXN_LSB] == EXN_NAN) ||
                                   (op_b[WIDTH:EXN_LSB] == EXN_NAN));
`endif
    for (int k = 1; k <= SUB_LAT; k++) begin
      tag_d[k] = tag_q[k-1];
    end
  end

  // Arbiter state; reset discards every in-flight tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        outst_q[i] <= '0;
      end
      for (int k = 0; k <= SUB_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        outst_q[i] <= outst_d[i];
      end
      for (int k = 0; k <= SUB_LAT; k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

  // Busy while any tag stage holds a live compare.
  always_comb begin
    busy = 1'b0;
    for (int k = 0; k <= SUB_LAT; k++) begin
      busy = busy | tag_q[k].valid;
    end
  end

`ifdef FP_CMP_UNORD_EN
  logic core_nan;

  fp_cmp_core #(.WIDTH(WIDTH), .SUB_LAT(SUB_LAT)) u_core (
    .clk   (clk),
    .rst   (rst),
    .x     (op_a),
    .y     (op_b),
    .r_nan (core_nan),
    .ge    (core_ge)
  );

  assign rsp_unord = tag_out.valid && (tag_out.unord || core_nan);
  assign rsp_ge    = tag_out.valid && core_ge && !rsp_unord;
`else
  fp_cmp_core #(.WIDTH(WIDTH), .SUB_LAT(SUB_LAT)) u_core (
    .clk (clk),
    .rst (rst),
    .x   (op_a),
    .y   (op_b),
    .ge  (core_ge)
  );

  assign rsp_ge = tag_out.valid && core_ge;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_cmp_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fp_cmp_arbiter                                                          |
// | Directed bench for fp_cmp_arbiter with a per-cycle reference model.        |
// | Optional feature macro: FP_CMP_UNORD_EN (checks rsp_unord).                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fp_cmp_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int WIDTH     = 36;
  localparam int SUB_LAT   = 2;
  localparam int OUTST_MAX = 2;
  localparam int OW        = WIDTH + 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*OW-1:0]   req_a, req_b;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic                    rsp_ge;
  logic                    busy;
`ifdef FP_CMP_UNORD_EN
  logic                    rsp_unord;
`endif

  fp_cmp_arbiter #(
    .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .SUB_LAT(SUB_LAT), .OUTST_MAX(OUTST_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ge    (rsp_ge),
`ifdef FP_CMP_UNORD_EN
    .rsp_unord (rsp_unord),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Encode a real into the operand format (exponent/mantissa match IEEE double).
  function automatic logic [WIDTH:0] fp(input real r);
    logic [63:0] b;
    if (r == 0.0) return '0;
    b = $realtobits(r);
    return {2'b01, b[63], b[62:52], b[51:29]};
  endfunction

  localparam logic [WIDTH:0] POS_INF = {2'b10, 35'd0};
  localparam logic [WIDTH:0] QNAN    = {2'b11, 35'd0};

  // ---------------- reference model ----------------
  function automatic real val(input logic [WIDTH:0] x);
    logic [1:0] e;
    e = x[WIDTH -: 2];
    if (e == 2'b00) return 0.0;
    if (e == 2'b01) return $bitstoreal({x[WIDTH-2], x[WIDTH-3 -: 11], x[22:0], 29'd0});
    return x[WIDTH-2] ? -1.0e300 : 1.0e300;
  endfunction

  function automatic bit m_unord(input logic [WIDTH:0] a, input logic [WIDTH:0] b);
    bit a_nan, b_nan, a_inf, b_inf;
    a_nan = (a[WIDTH -: 2] == 2'b11);
    b_nan = (b[WIDTH -: 2] == 2'b11);
    a_inf = (a[WIDTH -: 2] == 2'b10);
    b_inf = (b[WIDTH -: 2] == 2'b10);
    return a_nan || b_nan || (a_inf && b_inf && (a[WIDTH-2] == b[WIDTH-2]));
  endfunction

  typedef struct {
    int due;
    int id;
    bit ge;
    bit un;
  } exp_t;

  exp_t q[$];
  int   m_ptr = 0;
  int   m_outst [NUM_REQ];

  task automatic model_step();
    logic [NUM_REQ-1:0] e_rsp, e_rdy;
    logic [WIDTH:0]     a, b;
    bit                 e_ge, e_un;
    int                 rid, g, i;
    exp_t               ent;
    e_rsp = '0; e_ge = 1'b0; e_un = 1'b0; rid = -1; g = -1;
    if (rst) begin
      q.delete();
      m_ptr = 0;
      for (int r = 0; r < NUM_REQ; r++) m_outst[r] = 0;
    end else if (q.size() > 0 && q[0].due == cyc) begin
      rid = q[0].id;
      e_rsp[rid] = 1'b1;
      e_ge = q[0].ge;
      e_un = q[0].un;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      i = (m_ptr + k) % NUM_REQ;
      if (g < 0 && req_valid[i] &&
          (m_outst[i] < OUTST_MAX || (m_outst[i] == OUTST_MAX && rid == i))) g = i;
    end
    e_rdy = (g >= 0) ? (NUM_REQ'(1) << g) : '0;
    chk("model_req_ready", req_ready, e_rdy);
    chk("model_rsp_valid", rsp_valid, e_rsp);
    chk("model_rsp_ge", rsp_ge, e_ge);
`ifdef FP_CMP_UNORD_EN
    chk("model_rsp_unord", rsp_unord, e_un);
`endif
    chk("model_busy", busy, q.size() > 0);
    if (!rst) begin
      if (rid >= 0) begin
        void'(q.pop_front());
        m_outst[rid]--;
      end
      if (g >= 0) begin
        a = req_a[g*OW +: OW];
        b = req_b[g*OW +: OW];
        ent.due = cyc + SUB_LAT + 1;
        ent.id  = g;
        ent.un  = m_unord(a, b);
        ent.ge  = !ent.un && (val(a) >= val(b));
        q.push_back(ent);
        m_outst[g]++;
        m_ptr = (g + 1) % NUM_REQ;
      end
    end
  endtask

  // Model comparison every cycle, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    model_step();
  end

  // ---------------- directed stimulus ----------------
  task automatic single(input int id, input logic [WIDTH:0] a, input logic [WIDTH:0] b,
                        input bit exp_ge);
    @(posedge clk); #1;
    req_a[id*OW +: OW] = a;
    req_b[id*OW +: OW] = b;
    req_valid = NUM_REQ'(1) << id;
    @(negedge clk);
    chk("single_grant", req_ready, NUM_REQ'(1) << id);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(negedge clk);
    chk("single_rsp_valid", rsp_valid, NUM_REQ'(1) << id);
    chk("single_rsp_ge", rsp_ge, exp_ge);
  endtask

  logic [NUM_REQ-1:0] outst_pat [6] = '{4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0000};
  logic [NUM_REQ-1:0] rr_pat    [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic               rr_ge     [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    for (int r = 0; r < NUM_REQ; r++) m_outst[r] = 0;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_ge", rsp_ge, 0);
    chk("reset_busy", busy, 0);
    @(posedge clk); #1 rst = 1'b0;

    single(0, fp(2.0),  fp(1.0),  1'b1);
    single(1, fp(1.0),  fp(2.0),  1'b0);
    single(3, fp(-3.5), fp(-3.5), 1'b1);
    single(2, POS_INF,  fp(1.0),  1'b1);
    single(0, fp(1.0),  POS_INF,  1'b0);
    single(1, fp(-2.0), fp(0.0),  1'b0);
`ifdef FP_CMP_UNORD_EN
    single(2, QNAN, fp(0.0), 1'b0);
    chk("nan_rsp_unord", rsp_unord, 1);
`else
    single(2, QNAN, fp(0.0), 1'b0);
`endif

    // Requester 2 alone hits its outstanding limit.
    @(posedge clk); #1;
    req_a[2*OW +: OW] = fp(5.0);
    req_b[2*OW +: OW] = fp(4.0);
    req_valid = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("outst_ready", req_ready, outst_pat[k]);
    end
    @(posedge clk); #1 req_valid = '0;
    repeat (4) @(negedge clk);

    // Reset with three compares in flight.
    @(posedge clk); #1;
    for (int r = 0; r < NUM_REQ; r++) begin
      req_a[r*OW +: OW] = fp(1.5);
      req_b[r*OW +: OW] = fp(0.5);
    end
    req_valid = 4'b0111;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; req_valid = '0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post_rst_rsp_valid", rsp_valid, 0);
      chk("post_rst_busy", busy, 0);
    end
    @(posedge clk); #1 req_valid = 4'b1010;
    @(negedge clk);
    chk("post_rst_first_grant", req_ready, 4'b0010);
    @(posedge clk); #1 req_valid = '0;
    repeat (4) @(negedge clk);

    // All requesters valid: rotation from ptr=2 and routed responses.
    @(posedge clk); #1;
    req_a[0*OW +: OW] = fp(1.0);  req_b[0*OW +: OW] = fp(2.0);
    req_a[1*OW +: OW] = fp(2.0);  req_b[1*OW +: OW] = fp(1.0);
    req_a[2*OW +: OW] = fp(0.0);  req_b[2*OW +: OW] = fp(0.0);
    req_a[3*OW +: OW] = fp(-1.0); req_b[3*OW +: OW] = fp(1.0);
    req_valid = 4'b1111;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (k < 8) chk("rr_grant", req_ready, rr_pat[k % 4]);
      if (k >= 3) begin
        chk("rr_rsp_valid", rsp_valid, rr_pat[(k - 3) % 4]);
        chk("rr_rsp_ge", rsp_ge, rr_ge[(k - 3) % 4]);
      end
      if (k == 7) begin
        @(posedge clk); #1 req_valid = '0;
      end
    end
    repeat (3) @(negedge clk);
    chk("final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fp_cmp_arbiter.md
# fp_cmp_arbiter

Shares one pipelined floating-point greater-or-equal comparator among `NUM_REQ` requesters in the Ray/AABB slab-test datapath. It arbitrates round-robin and issues at most one compare per cycle into the subtractor pipeline. A tag shift register carries the requester ID alongside each compare, so every result is routed back to the requester that issued it. Per-requester outstanding counters bound in-flight work.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `WIDTH`, 36, operand MSB index; operands are `WIDTH+1` bits (2 exception, sign, 11 exponent, 23 mantissa)
- `SUB_LAT`, 2, latency of the FP subtractor in cycles
- `OUTST_MAX`, 3, maximum in-flight compares per requester (1..7)

Ports:
- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-high
- `req_valid` in `NUM_REQ`: compare request per requester
- `req_ready` out `NUM_REQ`: request accepted this cycle (grant)
- `req_a` in `NUM_REQ*(WIDTH+1)`: operand A, requester i at slice i
- `req_b` in `NUM_REQ*(WIDTH+1)`: operand B
- `rsp_valid` out `NUM_REQ`: one-cycle result pulse, one-hot or zero
- `rsp_ge` out 1: A >= B for the pulsing requester
- `rsp_unord` out 1: unordered flag; exists only with `FP_CMP_UNORD_EN`
- `busy` out 1: any compare in flight

## Operation
- Eligibility: requester i is eligible when `req_valid[i]` is high and `outst[i]` is below `OUTST_MAX`, or when `outst[i]` equals `OUTST_MAX` and its response retires this cycle.
- Arbitration: the first eligible requester at or after round-robin pointer `ptr`, in wrap order, is granted. `req_ready` is one-hot or zero and is combinational from the inputs and state.
- Pointer update: on a grant to i, `ptr` becomes (i+1) mod `NUM_REQ`. With no grant, `ptr` holds.
- Issue: the granted operands drive the subtractor as X=A, Y=B. The tag {valid, id} enters a shift register of depth `SUB_LAT`+1.
- Decision on the difference R (exception `R[WIDTH:WIDTH-1]`, sign `R[WIDTH-2]`), registered:
  - exn 00 (zero): ge=1
  - exn 01 or 10 with sign 0: ge=1
  - exn 01 or 10 with sign 1: ge=0
  - exn 11 (NaN): ge=0
- Response: `rsp_valid[id]` pulses when the tag reaches the output stage with valid set. `rsp_ge` is meaningful only while some `rsp_valid` bit is high; otherwise it is 0.
- Responses cannot be back-pressured. Requesters must sample them on the pulse.
- Counters: `outst[i]` increments on a grant and decrements on a response. When both happen in the same cycle, it is unchanged.
- `busy` is the OR of all tag valid bits.
- Reset mid-operation: all in-flight tags are discarded and no responses are emitted for them. `ptr`=0, all `outst`=0.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_ge`=0, `rsp_unord`=0, `busy`=0.
- Latency: a grant in cycle t produces `rsp_valid` in cycle t+`SUB_LAT`+1.
- Throughput: one grant per cycle in aggregate. A single requester is sustained at one compare per cycle when `OUTST_MAX` is at least `SUB_LAT`+1.
- Responses return in issue order, both per requester and globally.
- `req_valid` may drop without a grant, with no penalty; the arbiter holds no state for ungranted requests.

## Configuration
- `FP_CMP_UNORD_EN` defined:
  - `rsp_unord` port present.
  - Asserted with the response when either operand's exception field is 11 (detected at issue and carried in the tag), or when R's exception field is 11.
  - `rsp_ge` is forced to 0 whenever `rsp_unord` is asserted.
- Undefined: port absent, no extra tag bit. NaN is handled only through R per the decision table.

## Structure
- Shared package `fp_cmp_pkg`:
  - exception encodings `EXN_ZERO`, `EXN_NORM`, `EXN_INF`, `EXN_NAN`
  - field index constants derived from `WIDTH`
  - tag struct type {valid, id[2:0], unord}
- Sub-module `fp_cmp_core`:
  - wraps the FP subtractor plus the registered decision stage, latency `SUB_LAT`+1
  - the arbiter instantiates it once and keeps arbitration, tags and counters itself

## Test plan
- Single request: requester 0, A=2.0, B=1.0, granted at t -> `rsp_valid`=0001 at t+3 (`SUB_LAT`=2), `rsp_ge`=1. Then A=1.0, B=2.0 -> `rsp_ge`=0. A=B=-3.5 -> `rsp_ge`=1.
- All four requesters valid continuously -> grants 0,1,2,3,0,... one per cycle. Responses route to the matching ids in the same order, 3 cycles after each grant.
- Requester 2 alone with `OUTST_MAX`=2 -> grants at t and t+1, `req_ready[2]`=0 at t+2, grant resumes at t+3 as the first response retires.
- A=+inf, B=1.0 -> ge=1. A=1.0, B=+inf -> ge=0. With `FP_CMP_UNORD_EN`, A=NaN, B=0 -> `rsp_unord`=1, `rsp_ge`=0.
- Assert `rst` with 3 compares in flight -> no `rsp_valid` after reset release, `busy`=0. The first post-reset grant goes to the lowest valid id.
